// File: rtl/psram_line_fetch.sv
// Scanline prefetch: reads one display line of PSRAM words into the back half of a
// ping-pong line buffer. `PSRAM_LINE_DOUBLE_EN fetches each framebuffer line twice.
module psram_line_fetch #(
  parameter int unsigned LINE_WORDS = 640,
  parameter logic [23:0] FB_BASE    = 24'h000000,
  parameter int unsigned ADDR_STEP  = 2
) (
  input  logic        clk_100mhz,
  input  logic        rstn_i,
  input  logic        i_frame_start,
  input  logic        i_line_req,
  input  logic        i_line_swap,
  input  logic [9:0]  i_rd_col,
  output logic [11:0] o_rd_data,
  output logic        o_busy,
  output logic        o_underrun,
  output logic        o_psram_stb,
  output logic        o_psram_we,
  output logic [23:0] o_psram_addr,
  input  logic        i_psram_busy,
  input  logic        i_psram_done,
  input  logic [15:0] i_psram_dout
);

  localparam int unsigned     CntW     = $clog2(LINE_WORDS);
  localparam logic [23:0]     Step     = 24'(ADDR_STEP);
  localparam logic [23:0]     LineStep = 24'(LINE_WORDS * ADDR_STEP);
  localparam logic [CntW-1:0] LastWord = CntW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitDone, StFinish} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [23:0]     line_addr_q, line_addr_d;
  logic [23:0]     req_addr_q, req_addr_d;
  logic            busy_q, busy_d;
  logic            front_q, front_d;
  logic            underrun_q, underrun_d;
  logic [11:0]     rd_data_q, rd_data_d;
  logic            wr_en;

  logic [11:0] buf0 [LINE_WORDS];
  logic [11:0] buf1 [LINE_WORDS];

  logic unused_dout_hi;
  assign unused_dout_hi = ^i_psram_dout[15:12];

`ifdef PSRAM_LINE_DOUBLE_EN
  logic dbl_q, dbl_d;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_addr_d = line_addr_q;
    req_addr_d  = req_addr_q;
    busy_d      = busy_q;
    front_d     = front_q;
    underrun_d  = underrun_q;
    wr_en       = 1'b0;
`ifdef PSRAM_LINE_DOUBLE_EN
    dbl_d       = dbl_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (i_line_req) begin
          state_d    = StIssue;
          busy_d     = 1'b1;
          cnt_d      = '0;
          req_addr_d = i_frame_start ? FB_BASE : line_addr_q;
        end
      end
      StIssue: begin
        if (i_psram_busy) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (i_psram_done) begin
          wr_en      = 1'b1;
          cnt_d      = cnt_q + 1'b1;
          req_addr_d = req_addr_q + Step;
          state_d    = (cnt_q == LastWord) ? StFinish : StIssue;
        end
      end
      StFinish: begin
        busy_d  = 1'b0;
        state_d = StIdle;
`ifdef PSRAM_LINE_DOUBLE_EN
        dbl_d = ~dbl_q;
        if (dbl_q) line_addr_d = line_addr_q + LineStep;
`else
        line_addr_d = line_addr_q + LineStep;
`endif
      end
      default: state_d = StIdle;
    endcase

    // busy_q stays high through FINISH, so a swap there is suppressed too
    if (busy_q && (i_line_req || i_line_swap)) underrun_d = 1'b1;
    if (!busy_q && i_line_swap) front_d = ~front_q;

    if (i_frame_start) begin
      line_addr_d = FB_BASE;
      underrun_d  = 1'b0;
`ifdef PSRAM_LINE_DOUBLE_EN
      dbl_d       = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_100mhz or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      line_addr_q <= FB_BASE;
      req_addr_q  <= '0;
      busy_q      <= 1'b0;
      front_q     <= 1'b0;
      underrun_q  <= 1'b0;
      rd_data_q   <= '0;
`ifdef PSRAM_LINE_DOUBLE_EN
      dbl_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_addr_q <= line_addr_d;
      req_addr_q  <= req_addr_d;
      busy_q      <= busy_d;
      front_q     <= front_d;
      underrun_q  <= underrun_d;
      rd_data_q   <= rd_data_d;
`ifdef PSRAM_LINE_DOUBLE_EN
      dbl_q       <= dbl_d;
`endif
    end
  end

  // Back buffer is whichever half the pixel path is not reading
  always_ff @(posedge clk_100mhz) begin
    if (wr_en && front_q) buf0[cnt_q] <= i_psram_dout[11:0];
  end

  always_ff @(posedge clk_100mhz) begin
    if (wr_en && !front_q) buf1[cnt_q] <= i_psram_dout[11:0];
  end

  always_comb begin
    rd_data_d = '0;
    if (32'(i_rd_col) < LINE_WORDS) rd_data_d = front_q ? buf1[i_rd_col] : buf0[i_rd_col];
  end

  assign o_rd_data    = rd_data_q;
  assign o_busy       = busy_q;
  assign o_underrun   = underrun_q;
  assign o_psram_stb  = (state_q == StIssue);
  assign o_psram_we   = 1'b0;
  assign o_psram_addr = req_addr_q;

endmodule
